// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data memory between the core load/store port and the loader port.
// Defining DMEM_ARB_PERF_EN adds live stall/conflict cycle counters; otherwise perf_* are tied to zero.
module dmem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_rd,
   input  logic              c_wr,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wr_data,
   output logic [DATA_W-1:0] c_rd_data,
   output logic              c_stall,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wr_data,
   output logic              l_ack,
   output logic [DATA_W-1:0] l_rd_data,
   output logic              m_rd,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wr_data,
   input  logic [DATA_W-1:0] m_rd_data,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_conflict_cnt
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RD_WAIT = 1'b1;
   localparam logic       OWN_CORE   = 1'b0;
   localparam logic       OWN_LOAD   = 1'b1;
   localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);

   logic [0:0]        state_r;
   logic [0:0]        state_nxt_s;
   logic              owner_r;
   logic              owner_nxt_s;
   logic              last_grant_r;
   logic              last_grant_nxt_s;
   logic [1:0]        lat_cnt_r;
   logic [1:0]        lat_cnt_nxt_s;
   logic [DATA_W-1:0] c_rd_hold_r;
   logic [DATA_W-1:0] l_rd_hold_r;

   logic              core_req_s;
   logic              grant_core_s;
   logic              grant_load_s;
   logic              grant_we_s;
   logic              rd_ret_s;
   logic              ret_core_s;
   logic              ret_load_s;

   // arbitration: choose the winner of an IDLE cycle, the non-last_grant side wins a tie
   always_comb begin
      core_req_s   = c_rd | c_wr;
      grant_core_s = 1'b0;
      grant_load_s = 1'b0;
      if (!reset && (state_r == ST_IDLE)) begin
         if (core_req_s && l_req) begin
            if (last_grant_r == OWN_LOAD) begin
               grant_core_s = 1'b1;
            end else begin
               grant_load_s = 1'b1;
            end
         end else if (core_req_s) begin
            grant_core_s = 1'b1;
         end else if (l_req) begin
            grant_load_s = 1'b1;
         end else begin
            grant_core_s = 1'b0;
         end
      end else begin
         grant_core_s = 1'b0;
      end
   end

   // access type of the granted request and read-return detection
   always_comb begin
      grant_we_s = 1'b0;
      if (grant_core_s) begin
         grant_we_s = c_wr;
      end else if (grant_load_s) begin
         grant_we_s = l_we;
      end else begin
         grant_we_s = 1'b0;
      end
      rd_ret_s   = !reset && (state_r == ST_RD_WAIT) && (lat_cnt_r == 2'd0);
      ret_core_s = rd_ret_s && (owner_r == OWN_CORE);
      ret_load_s = rd_ret_s && (owner_r == OWN_LOAD);
   end

   // memory strobes, handshakes and read-data steering
   always_comb begin
      m_wr      = (grant_core_s | grant_load_s) & grant_we_s;
      m_rd      = (grant_core_s | grant_load_s) & ~grant_we_s;
      m_addr    = {ADDR_W{1'b0}};
      m_wr_data = {DATA_W{1'b0}};
      if (grant_core_s) begin
         m_addr    = c_addr;
         m_wr_data = c_wr_data;
      end else if (grant_load_s) begin
         m_addr    = l_addr;
         m_wr_data = l_wr_data;
      end else begin
         m_addr    = {ADDR_W{1'b0}};
      end
      // a core request is released only by its own write grant or its own read return
      if (reset || !core_req_s) begin
         c_stall = 1'b0;
      end else begin
         c_stall = !((grant_core_s && c_wr) || ret_core_s);
      end
      l_ack     = (grant_load_s & l_we) | ret_load_s;
      c_rd_data = ret_core_s ? m_rd_data : c_rd_hold_r;
      l_rd_data = ret_load_s ? m_rd_data : l_rd_hold_r;
   end

   // next-state logic for the IDLE / RD_WAIT sequencer
   always_comb begin
      state_nxt_s      = state_r;
      owner_nxt_s      = owner_r;
      last_grant_nxt_s = last_grant_r;
      lat_cnt_nxt_s    = lat_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_core_s || grant_load_s) begin
               last_grant_nxt_s = grant_load_s ? OWN_LOAD : OWN_CORE;
               if (!grant_we_s) begin
                  owner_nxt_s   = grant_load_s ? OWN_LOAD : OWN_CORE;
                  lat_cnt_nxt_s = LAT_INIT;
                  state_nxt_s   = ST_RD_WAIT;
               end else begin
                  state_nxt_s   = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (lat_cnt_r == 2'd0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               lat_cnt_nxt_s = lat_cnt_r - 2'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // sequencer state and held read data
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_CORE;
         last_grant_r <= OWN_LOAD;
         lat_cnt_r    <= 2'd0;
         c_rd_hold_r  <= {DATA_W{1'b0}};
         l_rd_hold_r  <= {DATA_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         owner_r      <= owner_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         lat_cnt_r    <= lat_cnt_nxt_s;
         if (ret_core_s) begin
            c_rd_hold_r <= m_rd_data;
         end
         if (ret_load_s) begin
            l_rd_hold_r <= m_rd_data;
         end
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] conflict_cnt_r;
   logic        conflict_s;

   assign conflict_s = !reset && (state_r == ST_IDLE) && core_req_s && l_req;

   // free-running event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r    <= 32'd0;
         conflict_cnt_r <= 32'd0;
      end else begin
         if (c_stall) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (conflict_s) begin
            conflict_cnt_r <= conflict_cnt_r + 32'd1;
         end
      end
   end

   assign perf_stall_cnt    = stall_cnt_r;
   assign perf_conflict_cnt = conflict_cnt_r;
`else
   assign perf_stall_cnt    = 32'd0;
   assign perf_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a MEM_LAT=2 memory model; perf checks follow DMEM_ARB_PERF_EN.
module tb_dmem_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int LAT    = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              c_rd, c_wr, l_req, l_we;
   logic [ADDR_W-1:0] c_addr, l_addr, m_addr;
   logic [DATA_W-1:0] c_wr_data, l_wr_data, m_wr_data, m_rd_data, c_rd_data, l_rd_data;
   logic              c_stall, l_ack, m_rd, m_wr;
   logic [31:0]       perf_stall_cnt, perf_conflict_cnt;

   int errors = 0;
   int checks = 0;
   int exp_stall = 0;
   int exp_conf = 0;
   logic mon_en = 1'b0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] pa [LAT];
   logic              pv [LAT];

   wr_t               wr_q [$];
   logic [DATA_W-1:0] c_rd_q [$];
   logic [DATA_W-1:0] l_rd_q [$];
   wr_t               mon_w;
   logic [ADDR_W-1:0] rd_addrs [3];
   logic [DATA_W-1:0] rd_vals [3];

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wr_data(c_wr_data),
      .c_rd_data(c_rd_data), .c_stall(c_stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wr_data(l_wr_data),
      .l_ack(l_ack), .l_rd_data(l_rd_data),
      .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
      .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
   );

   always #5 clk = ~clk;

   // memory model: read data appears LAT cycles after the m_rd cycle
   always @(posedge clk) begin
      if (m_wr) mem[m_addr] <= m_wr_data;
      pv[0] <= m_rd;
      pa[0] <= m_addr;
      for (int i = 1; i < LAT; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
   end
   assign m_rd_data = pv[LAT-1] ? mem[pa[LAT-1]] : 32'hBAD0_BAD0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
   endtask

   // one clock cycle: check strobes/handshakes at negedge, track expected perf events
   task automatic cyc(input string tag, input logic e_rd, input logic e_wr, input logic [ADDR_W-1:0] e_addr,
                      input logic e_stall, input logic e_ack, input logic tie);
      @(negedge clk);
      check({tag, ".m_rd"}, 64'(m_rd), 64'(e_rd));
      check({tag, ".m_wr"}, 64'(m_wr), 64'(e_wr));
      if (e_rd || e_wr) check({tag, ".m_addr"}, 64'(m_addr), 64'(e_addr));
      check({tag, ".c_stall"}, 64'(c_stall), 64'(e_stall));
      check({tag, ".l_ack"}, 64'(l_ack), 64'(e_ack));
      if (e_stall) exp_stall++;
      if (tie) exp_conf++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf(input string tag);
      @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
      check({tag, ".stall_cnt"}, 64'(perf_stall_cnt), 64'(exp_stall));
      check({tag, ".conflict_cnt"}, 64'(perf_conflict_cnt), 64'(exp_conf));
`else
      check({tag, ".stall_cnt"}, 64'(perf_stall_cnt), 64'd0);
      check({tag, ".conflict_cnt"}, 64'(perf_conflict_cnt), 64'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   // scoreboard: pop expected write/read results as the DUT produces them
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (m_wr) begin
            check("sb.wr_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
               mon_w = wr_q.pop_front();
               check("sb.wr_addr", 64'(m_addr), 64'(mon_w.addr));
               check("sb.wr_data", 64'(m_wr_data), 64'(mon_w.data));
            end
         end
         if (l_ack && !l_we) begin
            check("sb.l_rd_expected", 64'(l_rd_q.size() != 0), 64'd1);
            if (l_rd_q.size() != 0) check("sb.l_rd_data", 64'(l_rd_data), 64'(l_rd_q.pop_front()));
         end
         if (c_rd && !c_wr && !c_stall) begin
            check("sb.c_rd_expected", 64'(c_rd_q.size() != 0), 64'd1);
            if (c_rd_q.size() != 0) check("sb.c_rd_data", 64'(c_rd_data), 64'(c_rd_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      c_rd = 1'b0; c_wr = 1'b1; c_addr = 9'h1FF; c_wr_data = 32'hFFFF_FFFF;
      l_req = 1'b1; l_we = 1'b1; l_addr = 9'h1FE; l_wr_data = 32'h1234_5678;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.m_rd", 64'(m_rd), 64'd0);
      check("rst.m_wr", 64'(m_wr), 64'd0);
      check("rst.l_ack", 64'(l_ack), 64'd0);
      check("rst.c_stall", 64'(c_stall), 64'd0);
      check("rst.m_addr", 64'(m_addr), 64'd0);
      check("rst.m_wr_data", 64'(m_wr_data), 64'd0);
      check("rst.perf_stall", 64'(perf_stall_cnt), 64'd0);
      check("rst.perf_conf", 64'(perf_conflict_cnt), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // tie after reset: core first, loader next cycle
      c_wr = 1'b1; c_addr = 9'h001; c_wr_data = 32'h1111_1111;
      l_req = 1'b1; l_we = 1'b1; l_addr = 9'h002; l_wr_data = 32'h2222_2222;
      push_wr(9'h001, 32'h1111_1111);
      push_wr(9'h002, 32'h2222_2222);
      cyc("tie_core", 1'b0, 1'b1, 9'h001, 1'b0, 1'b0, 1'b1);
      c_wr = 1'b0;
      cyc("tie_load", 1'b0, 1'b1, 9'h002, 1'b0, 1'b1, 1'b0);
      l_req = 1'b0;

      l_req = 1'b1; l_we = 1'b1; l_addr = 9'h030; l_wr_data = 32'hA5A5_0030;
      push_wr(9'h030, 32'hA5A5_0030);
      cyc("l_wr", 1'b0, 1'b1, 9'h030, 1'b0, 1'b1, 1'b0);
      l_req = 1'b0;

      c_wr = 1'b1; c_addr = 9'h010; c_wr_data = 32'hDEAD_BEEF;
      push_wr(9'h010, 32'hDEAD_BEEF);
      cyc("c_wr", 1'b0, 1'b1, 9'h010, 1'b0, 1'b0, 1'b0);
      c_wr = 1'b0;

      c_rd = 1'b1; c_addr = 9'h010;
      c_rd_q.push_back(32'hDEAD_BEEF);
      for (int k = 0; k <= LAT; k++) cyc("c_rd", k == 0, 1'b0, 9'h010, k < LAT, 1'b0, 1'b0);
      c_rd = 1'b0;
      @(negedge clk);
      check("c_rd_hold", 64'(c_rd_data), 64'hDEAD_BEEF);
      @(posedge clk);
      #1;

      // both read continuously: LOAD, CORE, LOAD, each slot LAT+1 cycles
      c_rd = 1'b1; c_addr = 9'h010;
      l_req = 1'b1; l_we = 1'b0; l_addr = 9'h030;
      l_rd_q.push_back(32'hA5A5_0030);
      c_rd_q.push_back(32'hDEAD_BEEF);
      l_rd_q.push_back(32'hA5A5_0030);
      for (int t = 0; t < 3 * (LAT + 1); t++) begin
         int ph;
         logic own_load;
         ph = t % (LAT + 1);
         own_load = ((t / (LAT + 1)) % 2) == 0;
         cyc("rr", ph == 0, 1'b0, own_load ? 9'h030 : 9'h010,
             !(!own_load && ph == LAT), own_load && ph == LAT, ph == 0);
      end
      c_rd = 1'b0;
      l_req = 1'b0;
      @(negedge clk);
      check("l_rd_hold", 64'(l_rd_data), 64'hA5A5_0030);
      @(posedge clk);
      #1;
      check_perf("perf_mid");

      // reset during RD_WAIT discards the loader read
      l_req = 1'b1; l_we = 1'b0; l_addr = 9'h030;
      cyc("rst_grant", 1'b1, 1'b0, 9'h030, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_rd.m_rd", 64'(m_rd), 64'd0);
      check("rst_rd.m_wr", 64'(m_wr), 64'd0);
      check("rst_rd.l_ack", 64'(l_ack), 64'd0);
      check("rst_rd.m_addr", 64'(m_addr), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_stall = 0;
      exp_conf = 0;
      l_req = 1'b0;
      c_wr = 1'b1; c_addr = 9'h040; c_wr_data = 32'h4040_4040;
      push_wr(9'h040, 32'h4040_4040);
      cyc("post_rst", 1'b0, 1'b1, 9'h040, 1'b0, 1'b0, 1'b0);
      c_wr = 1'b0;

      // five write ties alternate LOAD/CORE, then three lone core reads
      c_wr = 1'b1; c_addr = 9'h050; c_wr_data = 32'h5050_5050;
      l_req = 1'b1; l_we = 1'b1; l_addr = 9'h060; l_wr_data = 32'h6060_6060;
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) push_wr(9'h060, 32'h6060_6060);
         else push_wr(9'h050, 32'h5050_5050);
         cyc("tie_w", 1'b0, 1'b1, (i % 2 == 0) ? 9'h060 : 9'h050, i % 2 == 0, i % 2 == 0, 1'b1);
      end
      c_wr = 1'b0;
      l_req = 1'b0;
      rd_addrs[0] = 9'h050; rd_vals[0] = 32'h5050_5050;
      rd_addrs[1] = 9'h060; rd_vals[1] = 32'h6060_6060;
      rd_addrs[2] = 9'h050; rd_vals[2] = 32'h5050_5050;
      for (int j = 0; j < 3; j++) begin
         c_rd = 1'b1; c_addr = rd_addrs[j];
         c_rd_q.push_back(rd_vals[j]);
         for (int k = 0; k <= LAT; k++) cyc("pf_rd", k == 0, 1'b0, rd_addrs[j], k < LAT, 1'b0, 1'b0);
      end
      c_rd = 1'b0;
      check_perf("perf_end");

      check("sb.wr_left", 64'(wr_q.size()), 64'd0);
      check("sb.c_rd_left", 64'(c_rd_q.size()), 64'd0);
      check("sb.l_rd_left", 64'(l_rd_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
